// File: rtl/common_pkg.sv
// Shared types and helpers for the one-hot encoder/decoder family.
// The beat struct carries a bin field sized for the widest supported encoder.
package common_pkg;

  localparam int ENC_BIN_MAX = 8;

  function automatic int onehot_width(input int bin_width);
    return 32'd2 << (bin_width - 32'd1);
  endfunction

  typedef struct packed {
    logic [ENC_BIN_MAX-1:0] bin;
    logic                   zero;
    logic                   multi;
  } enc_beat_t;

endpackage

// File: rtl/onehot_prio_enc.sv
// Combinational lowest-set-bit priority encoder with zero-hot and multi-hot flags.
// The bin field is zero-extended to the package-wide width.
module onehot_prio_enc
  import common_pkg::*;
#(
  parameter  int BIN_WIDTH    = 4,
  localparam int ONEHOT_WIDTH = onehot_width(BIN_WIDTH)
) (
  input  logic [ONEHOT_WIDTH-1:0] onehot,
  output enc_beat_t               beat
);

  logic [BIN_WIDTH-1:0]    low_idx_s;
  logic [ONEHOT_WIDTH-1:0] clr_low_s;

  // Scan high to low so the last hit, the lowest set bit, wins.
  always_comb begin
    low_idx_s = '0;
    for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
      low_idx_s = onehot[i] ? i[BIN_WIDTH-1:0] : low_idx_s;
    end
  end

  assign clr_low_s = onehot & (onehot - {{(ONEHOT_WIDTH-1){1'b0}}, 1'b1});

  always_comb begin
    beat                     = '0;
    beat.bin[BIN_WIDTH-1:0]  = low_idx_s;
    beat.zero                = (onehot == '0);
    beat.multi               = |clr_low_s;
  end

endmodule

// File: rtl/onehot_to_bin.sv
// Two-stage elastic one-hot-to-binary encoder with malformed-beat flags
// and a saturating error counter.
module onehot_to_bin
  import common_pkg::*;
#(
  parameter  int BIN_WIDTH     = 4,
  parameter  int ERR_CNT_WIDTH = 8,
  localparam int ONEHOT_WIDTH  = onehot_width(BIN_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ONEHOT_WIDTH-1:0]  onehot,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIN_WIDTH-1:0]     bin,
  output logic                     out_zero,
  output logic                     out_multi,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  input  logic                     err_clr
);

  logic                     s1_valid_q, s1_valid_d;
  logic [ONEHOT_WIDTH-1:0]  s1_onehot_q, s1_onehot_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [BIN_WIDTH-1:0]     bin_q, bin_d;
  logic                     zero_q, zero_d;
  logic                     multi_q, multi_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic      s2_load_s;
  logic      in_fire_s;
  logic      out_fire_s;
  logic      err_beat_s;
  enc_beat_t enc_s;

  onehot_prio_enc #(
    .BIN_WIDTH (BIN_WIDTH)
  ) u_enc (
    .onehot (s1_onehot_q),
    .beat   (enc_s)
  );

  generate
    if (BIN_WIDTH < ENC_BIN_MAX) begin : g_bin_hi
      logic unused_bin_hi_s;
      assign unused_bin_hi_s = ^enc_s.bin[ENC_BIN_MAX-1:BIN_WIDTH];
    end
  endgenerate

  // S2 frees up whenever its beat leaves; S1 may then refill in the same cycle.
  assign s2_load_s  = !s2_valid_q || out_ready;
  assign in_ready   = !rst && (!s1_valid_q || s2_load_s);
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = s2_valid_q && out_ready;
  assign err_beat_s = out_fire_s && (zero_q || multi_q);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_onehot_d = s1_onehot_q;
    if (in_fire_s) begin
      s1_valid_d  = 1'b1;
      s1_onehot_d = onehot;
    end else if (s2_load_s) begin
      s1_valid_d  = 1'b0;
    end else begin
      s1_valid_d  = s1_valid_q;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    bin_d      = bin_q;
    zero_d     = zero_q;
    multi_d    = multi_q;
    if (s2_load_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        bin_d   = enc_s.bin[BIN_WIDTH-1:0];
        zero_d  = enc_s.zero;
        multi_d = enc_s.multi;
      end else begin
        bin_d   = bin_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (err_beat_s && (err_count_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_count_d = err_count_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_onehot_q <= '0;
      s2_valid_q  <= 1'b0;
      bin_q       <= '0;
      zero_q      <= 1'b0;
      multi_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_onehot_q <= s1_onehot_d;
      s2_valid_q  <= s2_valid_d;
      bin_q       <= bin_d;
      zero_q      <= zero_d;
      multi_q     <= multi_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign bin       = bin_q;
  assign out_zero  = zero_q;
  assign out_multi = multi_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_onehot_to_bin.sv
// Directed bench for onehot_to_bin: one default instance plus one with a
// 2-bit error counter for saturation, clear and mid-stream reset scenarios.
module tb_onehot_to_bin;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] onehot;
  logic [3:0]  bin;
  logic        out_zero, out_multi, err_clr;
  logic [7:0]  err_count;

  logic        sat_in_valid, sat_in_ready, sat_out_valid, sat_out_ready;
  logic [15:0] sat_onehot;
  logic [3:0]  sat_bin;
  logic        sat_out_zero, sat_out_multi, sat_err_clr;
  logic [1:0]  sat_err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_to_bin #(.BIN_WIDTH(4), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .onehot(onehot), .out_valid(out_valid), .out_ready(out_ready),
    .bin(bin), .out_zero(out_zero), .out_multi(out_multi),
    .err_count(err_count), .err_clr(err_clr)
  );

  onehot_to_bin #(.BIN_WIDTH(4), .ERR_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
    .onehot(sat_onehot), .out_valid(sat_out_valid), .out_ready(sat_out_ready),
    .bin(sat_bin), .out_zero(sat_out_zero), .out_multi(sat_out_multi),
    .err_count(sat_err_count), .err_clr(sat_err_clr)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; onehot = '0; out_ready = 1'b0; err_clr = 1'b0;
    sat_in_valid = 1'b0; sat_onehot = '0; sat_out_ready = 1'b0; sat_err_clr = 1'b0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (bin !== 4'd0) begin errors++; $display("FAIL reset_bin got %0d exp 0", bin); end
    checks++; if ({out_zero, out_multi} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {out_zero, out_multi}); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
    checks++; if (sat_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_sat_in_ready got %b exp 1", sat_in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_valid = 1'b1; onehot = 16'h0020;
    step();
    in_valid = 1'b0; onehot = 16'hxxxx;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency out_valid got %b exp 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
    checks++; if (bin !== 4'd5) begin errors++; $display("FAIL single_bin got %0d exp 5", bin); end
    checks++; if ({out_zero, out_multi} !== 2'b00) begin errors++; $display("FAIL single_flags got %b exp 00", {out_zero, out_multi}); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL single_err_count got %0d exp 0", err_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_zero();
    in_valid = 1'b1; onehot = 16'h0000;
    step();
    in_valid = 1'b0; onehot = 16'hxxxx;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_out_valid got %b exp 1", out_valid); end
    checks++; if (bin !== 4'd0) begin errors++; $display("FAIL zero_bin got %0d exp 0", bin); end
    checks++; if ({out_zero, out_multi} !== 2'b10) begin errors++; $display("FAIL zero_flags got %b exp 10", {out_zero, out_multi}); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL zero_err_before got %0d exp 0", err_count); end
    step();
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL zero_err_after got %0d exp 1", err_count); end
  endtask

  task automatic test_multi();
    in_valid = 1'b1; onehot = 16'h0110;
    step();
    in_valid = 1'b0; onehot = 16'hxxxx;
    step();
    checks++; if (bin !== 4'd4) begin errors++; $display("FAIL multi_bin got %0d exp 4", bin); end
    checks++; if ({out_zero, out_multi} !== 2'b01) begin errors++; $display("FAIL multi_flags got %b exp 01", {out_zero, out_multi}); end
    step();
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL multi_err_after got %0d exp 2", err_count); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b exp 1", c, in_ready); end
      end
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1 || bin !== 4'(c - 2)) begin errors++; $display("FAIL b2b_out cycle %0d got valid %b bin %0d exp valid 1 bin %0d", c, out_valid, bin, c - 2); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_fill cycle %0d out_valid got %b exp 0", c, out_valid); end
      end
      if (c < 16) begin
        in_valid = 1'b1; onehot = 16'h0001 << c;
      end else begin
        in_valid = 1'b0; onehot = 16'h0000;
      end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain out_valid got %b exp 0", out_valid); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL b2b_err_count got %0d exp 2", err_count); end
  endtask

  task automatic test_stall();
    logic [3:0] exp_bin [4];
    int sent;
    int recv;
    exp_bin[0] = 4'd3; exp_bin[1] = 4'd7; exp_bin[2] = 4'd9; exp_bin[3] = 4'd12;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 20 && recv < 4; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      onehot    = (sent < 4) ? (16'h0001 << exp_bin[sent]) : 16'h0000;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b exp 0", cyc, in_ready); end
        checks++; if (out_valid !== 1'b1 || bin !== exp_bin[0]) begin errors++; $display("FAIL stall_hold cycle %0d got valid %b bin %0d exp valid 1 bin %0d", cyc, out_valid, bin, exp_bin[0]); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (recv >= 4) begin
          errors++; $display("FAIL stall_dup extra beat bin %0d after %0d beats", bin, recv);
        end else if (bin !== exp_bin[recv]) begin
          errors++; $display("FAIL stall_order beat %0d got bin %0d exp %0d", recv, bin, exp_bin[recv]);
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (recv != 4 || sent != 4) begin errors++; $display("FAIL stall_count got sent %0d recv %0d exp 4 4", sent, recv); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    sat_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        checks++; if (sat_err_count !== 2'd2) begin errors++; $display("FAIL sat_partial got %0d exp 2", sat_err_count); end
      end
      sat_in_valid = 1'b1; sat_onehot = 16'h0000;
      step();
    end
    sat_in_valid = 1'b0;
    step(); step(); step();
    checks++; if (sat_err_count !== 2'd3) begin errors++; $display("FAIL sat_full got %0d exp 3", sat_err_count); end
    checks++; if (sat_out_valid !== 1'b0) begin errors++; $display("FAIL sat_drain out_valid got %b exp 0", sat_out_valid); end
  endtask

  task automatic test_err_clr();
    sat_in_valid = 1'b1; sat_onehot = 16'h0000;
    step();
    sat_in_valid = 1'b0;
    step();
    checks++; if (sat_out_valid !== 1'b1 || sat_out_zero !== 1'b1) begin errors++; $display("FAIL clr_setup got valid %b zero %b exp 1 1", sat_out_valid, sat_out_zero); end
    sat_err_clr = 1'b1;
    step();
    sat_err_clr = 1'b0;
    checks++; if (sat_err_count !== 2'd0) begin errors++; $display("FAIL clr_wins got %0d exp 0", sat_err_count); end
    sat_in_valid = 1'b1; sat_onehot = 16'h8001;
    step();
    sat_in_valid = 1'b0;
    step(); step();
    checks++; if (sat_err_count !== 2'd1) begin errors++; $display("FAIL clr_recount got %0d exp 1", sat_err_count); end
  endtask

  task automatic test_reset_midstream();
    sat_out_ready = 1'b0;
    sat_in_valid = 1'b1; sat_onehot = 16'h0000;
    step(); step();
    sat_in_valid = 1'b0;
    checks++; if (sat_in_ready !== 1'b0 || sat_out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got in_ready %b out_valid %b exp 0 1", sat_in_ready, sat_out_valid); end
    rst = 1'b1;
    step();
    checks++; if (sat_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", sat_out_valid); end
    checks++; if (sat_err_count !== 2'd0) begin errors++; $display("FAIL mid_err_count got %0d exp 0", sat_err_count); end
    checks++; if (sat_in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready_rst got %b exp 0", sat_in_ready); end
    checks++; if ({sat_bin, sat_out_zero, sat_out_multi} !== 6'd0) begin errors++; $display("FAIL mid_fields got %b exp 000000", {sat_bin, sat_out_zero, sat_out_multi}); end
    rst = 1'b0; sat_out_ready = 1'b1;
    #1;
    checks++; if (sat_in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready_release got %b exp 1", sat_in_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (sat_out_valid !== 1'b0 || sat_err_count !== 2'd0) begin errors++; $display("FAIL mid_discard cycle %0d got valid %b err %0d exp 0 0", c, sat_out_valid, sat_err_count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_multi();
    test_back_to_back();
    test_stall();
    test_saturation();
    test_err_clr();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
